// File: rtl/led_count_sequencer.sv
// Command-driven sequencer producing step/clear strobes for the LED demo counter.
// Optional wrap guard enabled by defining LED_SEQ_WRAP_GUARD_EN.
module led_count_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             cnt_at_max,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] OP_STOP  = 2'd0;
    localparam logic [1:0] OP_RUN   = 2'd1;
    localparam logic [1:0] OP_BURST = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BURST,
        S_CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             sat_q, sat_d;

    logic active;
    logic strobeSlot;
    logic guardHit;
    logic accept;

    // Strobes are decoded from registered state so downstream sees glitch-free enables.
    assign active     = (state_q == S_RUN) || (state_q == S_BURST);
    assign strobeSlot = active && (pre_q == PRE_MAX);

`ifdef LED_SEQ_WRAP_GUARD_EN
    assign guardHit = strobeSlot && cnt_at_max;
    assign sat      = sat_q;
`else
    logic unused_guard;
    assign guardHit     = 1'b0;
    assign sat          = 1'b0;
    assign unused_guard = cnt_at_max ^ sat_q;
`endif

    assign cnt_en    = strobeSlot && !guardHit;
    assign cnt_clr   = (state_q == S_CLEAR);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign cmd_ready = (state_q != S_CLEAR);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        pre_d       = '0;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        sat_d       = sat_q;

        if (cnt_en && (state_q == S_BURST)) begin
            remaining_d = remaining_q - 1'b1;
        end
        if (guardHit) begin
            sat_d = 1'b1;
        end

        // An accepted command always decides the next state, even on a strobe cycle.
        if (accept) begin
            case (cmd_op)
                OP_STOP: state_d = S_IDLE;
                OP_RUN:  state_d = S_RUN;
                OP_BURST: begin
                    if (cmd_arg != '0) begin
                        state_d     = S_BURST;
                        remaining_d = cmd_arg;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                OP_CLEAR: begin
                    state_d = S_CLEAR;
                    sat_d   = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_CLEAR: state_d = S_IDLE;
                S_RUN, S_BURST: begin
                    if (guardHit) begin
                        state_d = S_IDLE;
                        done_d  = (state_q == S_BURST);
                    end else if (cnt_en && (state_q == S_BURST) && (remaining_q == WIDTH'(1))) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_led_count_sequencer.sv
// Self-checking bench for led_count_sequencer: directed timing pins plus randomized
// commands compared every cycle against a cycle-count based reference model.
module tb_led_count_sequencer;

    localparam int WIDTH    = 8;
    localparam int PRESCALE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_arg = '0;
    logic             cnt_at_max = 1'b0;
    logic             cnt_en, cnt_clr, busy, done, sat;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 run, 2 burst, 3 clear; mJ is the cycle number since the run started.
    int mMode = 0;
    int mJ    = 0;
    int mLeft = 0;
    bit mDone = 1'b0;
    bit mSat  = 1'b0;

    led_count_sequencer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cnt_at_max(cnt_at_max),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .done(done), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic bit wouldStep();
        return ((mMode == 1) || (mMode == 2)) && ((mJ % PRESCALE) == 0);
    endfunction

    function automatic bit guardNow();
        bit g;
        g = 1'b0;
`ifdef LED_SEQ_WRAP_GUARD_EN
        g = wouldStep() && cnt_at_max;
`endif
        return g;
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mMode = 0; mJ = 0; mLeft = 0; mDone = 1'b0; mSat = 1'b0;
        end else begin : modelStep
            bit hit, en, acc;
            hit   = guardNow();
            en    = wouldStep() && !hit;
            acc   = cmd_valid && (mMode != 3);
            mDone = 1'b0;
            if (hit) mSat = 1'b1;
            if (acc) begin
                case (cmd_op)
                    2'd0: mMode = 0;
                    2'd1: begin mMode = 1; mJ = 1; end
                    2'd2: begin
                        if (cmd_arg != 0) begin mMode = 2; mJ = 1; mLeft = int'(cmd_arg); end
                        else begin mMode = 0; mDone = 1'b1; end
                    end
                    default: begin mMode = 3; mSat = 1'b0; end
                endcase
            end else if (mMode == 3) begin
                mMode = 0;
            end else if (mMode != 0) begin
                if (hit) begin
                    mDone = (mMode == 2);
                    mMode = 0;
                end else begin
                    if (en && (mMode == 2)) begin
                        mLeft--;
                        if (mLeft == 0) begin mMode = 0; mDone = 1'b1; end
                    end
                    mJ++;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("cnt_en",    cnt_en,    wouldStep() && !guardNow());
        checkOutput("cnt_clr",   cnt_clr,   mMode == 3);
        checkOutput("busy",      busy,      mMode != 0);
        checkOutput("cmd_ready", cmd_ready, mMode != 3);
        checkOutput("done",      done,      mDone);
        checkOutput("sat",       sat,       mSat);
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] arg);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic watch(input int n, output int enCnt, output int enFirst, output int enLast,
                         output int doneCnt, output int doneAt, output int busyCnt);
        enCnt = 0; enFirst = -1; enLast = -1; doneCnt = 0; doneAt = -1; busyCnt = 0;
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (cnt_en) begin
                enCnt++;
                if (enFirst < 0) enFirst = j;
                enLast = j;
            end
            if (done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = j;
            end
            if (busy) busyCnt++;
        end
    endtask

    initial begin
        int enCnt, enFirst, enLast, doneCnt, doneAt, busyCnt;
        int clrCnt, clrAt, rdyLowCnt, rdyLowAt, busy2, busy3;

        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready", cmd_ready, 1'b1);
        checkOutput("reset_busy",  busy,      1'b0);

        applyStimulus(2'd1, '0);
        watch(12, enCnt, enFirst, enLast, doneCnt, doneAt, busyCnt);
        checkInt("run_en_count", enCnt, 3);
        checkInt("run_en_first", enFirst, 4);
        checkInt("run_en_last",  enLast, 12);
        checkInt("run_busy",     busyCnt, 12);
        applyStimulus(2'd0, '0);
        watch(6, enCnt, enFirst, enLast, doneCnt, doneAt, busyCnt);
        checkInt("stop_en_count", enCnt, 0);
        checkInt("stop_busy",     busyCnt, 0);

        applyStimulus(2'd2, 8'd3);
        watch(16, enCnt, enFirst, enLast, doneCnt, doneAt, busyCnt);
        checkInt("burst3_en_count", enCnt, 3);
        checkInt("burst3_en_first", enFirst, 4);
        checkInt("burst3_en_last",  enLast, 12);
        checkInt("burst3_done_cnt", doneCnt, 1);
        checkInt("burst3_done_at",  doneAt, 13);
        checkInt("burst3_busy",     busyCnt, 12);

        applyStimulus(2'd2, 8'd0);
        watch(5, enCnt, enFirst, enLast, doneCnt, doneAt, busyCnt);
        checkInt("burst0_en_count", enCnt, 0);
        checkInt("burst0_done_at",  doneAt, 1);
        checkInt("burst0_done_cnt", doneCnt, 1);
        checkInt("burst0_busy",     busyCnt, 0);

        // CLEAR during RUN with valid held high; a RUN follows and is accepted at edge 2.
        applyStimulus(2'd1, '0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        @(posedge clk);
        #1;
        cmd_op = 2'd1;
        clrCnt = 0; clrAt = -1; rdyLowCnt = 0; rdyLowAt = -1; doneCnt = 0; enFirst = -1;
        busy2 = -1; busy3 = -1;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (cnt_clr) begin clrCnt++; if (clrAt < 0) clrAt = j; end
            if (!cmd_ready) begin rdyLowCnt++; if (rdyLowAt < 0) rdyLowAt = j; end
            if (done) doneCnt++;
            if (cnt_en && enFirst < 0) enFirst = j;
            if (j == 2) busy2 = int'(busy);
            if (j == 3) begin busy3 = int'(busy); cmd_valid = 1'b0; end
        end
        checkInt("clear_clr_cnt",   clrCnt, 1);
        checkInt("clear_clr_at",    clrAt, 1);
        checkInt("clear_rdy_low",   rdyLowCnt, 1);
        checkInt("clear_rdy_at",    rdyLowAt, 1);
        checkInt("clear_no_done",   doneCnt, 0);
        checkInt("clear_busy_c2",   busy2, 0);
        checkInt("clear_busy_c3",   busy3, 1);
        checkInt("clear_run_en_at", enFirst, 6);

        applyStimulus(2'd2, 8'd10);
        repeat (7) @(negedge clk);
        checkOutput("midburst_busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_cnt_en",  cnt_en,    1'b0);
        checkOutput("arst_cnt_clr", cnt_clr,   1'b0);
        checkOutput("arst_busy",    busy,      1'b0);
        checkOutput("arst_done",    done,      1'b0);
        checkOutput("arst_sat",     sat,       1'b0);
        checkOutput("arst_ready",   cmd_ready, 1'b1);
        @(negedge clk);
        #1 rst = 1'b0;
        watch(60, enCnt, enFirst, enLast, doneCnt, doneAt, busyCnt);
        checkInt("arst_no_done", doneCnt, 0);
        checkInt("arst_no_en",   enCnt, 0);
        checkInt("arst_idle",    busyCnt, 0);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst        = ($urandom_range(0, 499) == 0);
            cmd_valid  = ($urandom_range(0, 9) < 3);
            cmd_op     = 2'($urandom_range(0, 3));
            cmd_arg    = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom_range(0, 255))
                                                      : WIDTH'($urandom_range(0, 6));
            cnt_at_max = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
